// File: rtl/boron_pkg.sv
// rtl/boron_pkg.sv - Boron S-box tables, FSM state type and sizing helper (inverse table used only with BORON_SBOX_INV_EN)
package boron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
    4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
  };

  function automatic int nibble_count(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/boron_sbox4.sv
// rtl/boron_sbox4.sv - combinational 4-bit Boron S-box; inverse path only with BORON_SBOX_INV_EN
module boron_sbox4
  import boron_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dec,
  output logic [3:0] sub
);

`ifdef BORON_SBOX_INV_EN
  assign sub = dec ? SBOX_INV[nib] : SBOX_FWD[nib];
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign sub = SBOX_FWD[nib];
`endif

endmodule

// File: rtl/boron_sbox_layer.sv
// rtl/boron_sbox_layer.sv - time-multiplexed Boron substitution layer; BORON_SBOX_INV_EN enables in_dec_i
module boron_sbox_layer
  import boron_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_dec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int LSAFE = (LANES < 1) ? 1 : LANES;
  localparam int NCYC  = nibble_count(WIDTH) / LSAFE;
  localparam int CW    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  if ((LANES < 1) || (WIDTH % (4 * LSAFE) != 0)) begin : g_bad_cfg
    $error("boron_sbox_layer: WIDTH must be a multiple of 4*LANES and LANES >= 1");
  end

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             mode_q;
  logic             next_mode;
  logic [3:0]       lane_in  [LSAFE];
  logic [3:0]       lane_out [LSAFE];

`ifdef BORON_SBOX_INV_EN
  assign next_mode = in_dec_i;
`else
  logic unused_in_dec;
  assign unused_in_dec = in_dec_i;
  assign next_mode     = 1'b0;
`endif

  // Lane l of beat cnt works on nibble cnt*LANES+l, lowest nibbles first.
  always_comb begin
    for (int l = 0; l < LSAFE; l++) begin
      lane_in[l] = data_q[4*(int'(cnt_q)*LSAFE + l) +: 4];
    end
  end

  for (genvar g = 0; g < LSAFE; g++) begin : g_lane
    boron_sbox4 u_sbox4 (
      .nib (lane_in[g]),
      .dec (mode_q),
      .sub (lane_out[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q  <= in_data_i;
            mode_q  <= next_mode;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LSAFE; l++) begin
            data_q[4*(int'(cnt_q)*LSAFE + l) +: 4] <= lane_out[l];
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            if (in_valid_i) begin
              data_q  <= in_data_i;
              mode_q  <= next_mode;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Partial results never leave the block: data is visible only in DONE.
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = out_valid_o ? data_q : '0;
  assign in_ready_o  = rst_ni & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));

endmodule

// File: tb/tb_boron_sbox_layer.sv
// tb/tb_boron_sbox_layer.sv - directed bench for boron_sbox_layer at LANES 4, 16 and 1
module tb_boron_sbox_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [63:0] din;
  logic        dec;
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [63:0] od [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  boron_sbox_layer #(.WIDTH(64), .LANES(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld[0]), .in_ready_o(ir[0]),
    .in_data_i(din), .in_dec_i(dec), .out_valid_o(ov[0]), .out_ready_i(rdy[0]),
    .out_data_o(od[0])
  );

  boron_sbox_layer #(.WIDTH(64), .LANES(16)) u_l16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld[1]), .in_ready_o(ir[1]),
    .in_data_i(din), .in_dec_i(dec), .out_valid_o(ov[1]), .out_ready_i(rdy[1]),
    .out_data_o(od[1])
  );

  boron_sbox_layer #(.WIDTH(64), .LANES(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld[2]), .in_ready_o(ir[2]),
    .in_data_i(din), .in_dec_i(dec), .out_valid_o(ov[2]), .out_ready_i(rdy[2]),
    .out_data_o(od[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int sel, output int cyc);
    cyc = 0;
    while (ov[sel] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run(input int sel, input logic [63:0] d, input logic dm,
                     input int lat, input logic [63:0] exp, input string tag);
    int cyc;
    check({tag, "_in_ready"}, 64'(ir[sel]), 64'd1);
    din      = d;
    dec      = dm;
    vld[sel] = 1'b1;
    tick();
    vld[sel] = 1'b0;
    dec      = 1'b0;
    wait_valid(sel, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_data"}, od[sel], exp);
    rdy[sel] = 1'b1;
    tick();
    rdy[sel] = 1'b0;
    check({tag, "_valid_drop"}, 64'(ov[sel]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    vld   = '0;
    rdy   = '0;
    din   = '0;
    dec   = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(ir[0]), 64'd0);
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_out_data", od[0], 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(ir[0]), 64'd1);

    run(0, 64'h0000000000000000, 1'b0, 4, 64'hEEEEEEEEEEEEEEEE, "fwd_zero");
    run(0, 64'h0123456789ABCDEF, 1'b0, 4, 64'hE4B179CAD20F8536, "fwd_count");
`ifdef BORON_SBOX_INV_EN
    run(0, 64'hE4B179CAD20F8536, 1'b1, 4, 64'h0123456789ABCDEF, "inv_count");
`else
    run(0, 64'hE4B179CAD20F8536, 1'b1, 4, 64'h37F4A2805BE6D91C, "dec_ignored");
`endif

    // Backpressure: hold DONE for 10 cycles while a new state waits.
    din    = 64'h0123456789ABCDEF;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    wait_valid(0, cyc);
    check("bp_latency", 64'(cyc), 64'd4);
    din    = 64'hFFFFFFFFFFFFFFFF;
    vld[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(ov[0]), 64'd1);
      check("bp_data", od[0], 64'hE4B179CAD20F8536);
      check("bp_in_ready", 64'(ir[0]), 64'd0);
    end
    rdy[0] = 1'b1;
    #1;
    check("b2b_in_ready", 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    vld[0] = 1'b0;
    check("b2b_busy_valid", 64'(ov[0]), 64'd0);
    wait_valid(0, cyc);
    check("b2b_latency", 64'(cyc), 64'd4);
    check("b2b_data", od[0], 64'h6666666666666666);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check("b2b_valid_drop", 64'(ov[0]), 64'd0);

    // Reset while BUSY with cnt=2.
    din    = 64'h0123456789ABCDEF;
    vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_in_ready_low", 64'(ir[0]), 64'd0);
    rst_n = 1'b1;
    #1;
    check("abort_out_valid", 64'(ov[0]), 64'd0);
    check("abort_out_data", od[0], 64'd0);
    check("abort_in_ready", 64'(ir[0]), 64'd1);
    repeat (5) tick();
    check("abort_no_emit", 64'(ov[0]), 64'd0);
    run(0, 64'h0123456789ABCDEF, 1'b0, 4, 64'hE4B179CAD20F8536, "after_abort");

    run(1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1, 64'h6666666666666666, "lanes16");
    run(2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 16, 64'h6666666666666666, "lanes1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
